// File: rtl/wb_uart_tx_fifo.sv
// wb_uart_tx_fifo: Wishbone client UART transmitter; TX FIFO drained by an 8N1 serializer (optional parity).
// Latency: ACK one cycle after request; first start bit on UART_SOUT_o two cycles after the TXDATA ACK.
// Backpressure: none on the bus; a push into a full FIFO is dropped and sets the sticky OVERRUN flag.
//
// Ports:
//   WB_CLK, WB_RST            sole clock, asynchronous active-high reset
//   WBs_ADR/CYC/STB/WE        Wishbone request (byte address, bits [1:0] ignored)
//   WBs_BYTE_STB, WBs_WR_DAT  byte enables and write data
//   WBs_RD_DAT, WBs_ACK       registered read data, single-cycle acknowledge
//   UART_SOUT_o               serial out, idle high
//   UART_Intr_o               level interrupt (TX done / overrun)
// Build option: define WB_UART_TX_PARITY_EN to add CTRL[2]=PAR_EN, CTRL[3]=PAR_ODD and a parity bit.
module wb_uart_tx_fifo #(
  parameter int          ADDRWIDTH          = 10,
  parameter int          FIFO_DEPTH_LOG2    = 4,
  parameter logic [15:0] BAUD_DIV_DEFAULT   = 16'd68,
  parameter logic [31:0] DEFAULT_READ_VALUE = 32'hBAD_FAB_AC
) (
  input  logic                 WB_CLK,
  input  logic                 WB_RST,
  input  logic [ADDRWIDTH-1:0] WBs_ADR,
  input  logic                 WBs_CYC,
  input  logic                 WBs_STB,
  input  logic                 WBs_WE,
  input  logic [3:0]           WBs_BYTE_STB,
  input  logic [31:0]          WBs_WR_DAT,
  output logic [31:0]          WBs_RD_DAT,
  output logic                 WBs_ACK,
  output logic                 UART_SOUT_o,
  output logic                 UART_Intr_o
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
`ifdef WB_UART_TX_PARITY_EN
  localparam int CTRL_W = 4;
`else
  localparam int CTRL_W = 2;
`endif

  localparam logic [ADDRWIDTH-3:0] OFF_TX   = 0;
  localparam logic [ADDRWIDTH-3:0] OFF_ST   = 1;
  localparam logic [ADDRWIDTH-3:0] OFF_BAUD = 2;
  localparam logic [ADDRWIDTH-3:0] OFF_CTRL = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef WB_UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  logic                       w_req, w_wr;
  logic [ADDRWIDTH-3:0]       w_off;
  logic                       w_sel_tx, w_sel_st, w_sel_baud, w_sel_ctrl;
  logic                       w_push_req, w_push, w_pop;
  logic                       w_empty, w_full, w_busy;
  logic [31:0]                w_status, w_rd_mux;
  logic                       w_unused_ok;

  logic [7:0]                 r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [CW-1:0]              r_count;
  logic [15:0]                r_baud, r_div, r_cnt;
  logic [CTRL_W-1:0]          r_ctrl;
  logic                       r_overrun;
  state_t                     r_state;
  logic [7:0]                 r_shift;
  logic [2:0]                 r_bitidx;
  logic                       r_sout;
`ifdef WB_UART_TX_PARITY_EN
  logic                       r_par_en, r_par_bit;
`endif

  // Masking with ~ACK turns a held request into one transfer every two cycles.
  assign w_req      = WBs_CYC & WBs_STB & ~WBs_ACK;
  assign w_wr       = w_req & WBs_WE;
  assign w_off      = WBs_ADR[ADDRWIDTH-1:2];
  assign w_sel_tx   = (w_off == OFF_TX);
  assign w_sel_st   = (w_off == OFF_ST);
  assign w_sel_baud = (w_off == OFF_BAUD);
  assign w_sel_ctrl = (w_off == OFF_CTRL);

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_busy     = (r_state != S_IDLE);
  // Full is the pre-edge flag: a same-cycle pop does not make room for the push.
  assign w_push_req = w_wr & w_sel_tx & WBs_BYTE_STB[0];
  assign w_push     = w_push_req & ~w_full;
  // Pop from IDLE or on the last STOP cycle, so queued bytes go out without an idle gap.
  assign w_pop      = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & (r_cnt == '0)));

  assign UART_SOUT_o = r_sout;
  assign UART_Intr_o = (r_ctrl[0] & w_empty & ~w_busy) | (r_ctrl[1] & r_overrun);
  assign w_unused_ok = &{1'b0, WBs_ADR[1:0], WBs_BYTE_STB[3:2], WBs_WR_DAT[31:16]};

  always_comb begin
    w_status                       = '0;
    w_status[FIFO_DEPTH_LOG2+8:8]  = r_count;
    w_status[3]                    = r_overrun;
    w_status[2]                    = w_busy;
    w_status[1]                    = w_full;
    w_status[0]                    = w_empty;
  end

  always_comb begin
    w_rd_mux = DEFAULT_READ_VALUE;
    if (w_sel_tx)        w_rd_mux = '0;
    else if (w_sel_st)   w_rd_mux = w_status;
    else if (w_sel_baud) w_rd_mux = {16'h0000, r_baud};
    else if (w_sel_ctrl) w_rd_mux = 32'(r_ctrl);
  end

  // Bus side: acknowledge, read capture and register writes share the acknowledging edge.
  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) begin
      WBs_ACK    <= 1'b0;
      WBs_RD_DAT <= '0;
      r_baud     <= BAUD_DIV_DEFAULT;
      r_ctrl     <= '0;
      r_overrun  <= 1'b0;
    end else begin
      WBs_ACK <= w_req;
      if (w_req) WBs_RD_DAT <= w_rd_mux;
      if (w_wr & w_sel_baud) begin
        if (WBs_BYTE_STB[0]) r_baud[7:0]  <= WBs_WR_DAT[7:0];
        if (WBs_BYTE_STB[1]) r_baud[15:8] <= WBs_WR_DAT[15:8];
      end
      if (w_wr & w_sel_ctrl & WBs_BYTE_STB[0]) r_ctrl <= WBs_WR_DAT[CTRL_W-1:0];
      if (w_push_req & w_full)
        r_overrun <= 1'b1;
      else if (w_wr & w_sel_st & WBs_BYTE_STB[0] & WBs_WR_DAT[3])
        r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge WB_CLK) begin
    if (w_push) r_mem[r_wptr] <= WBs_WR_DAT[7:0];
  end

  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Serializer. r_sout is the registered image of the current state's bit, so the
  // whole frame appears on the pin one cycle after the state that produces it.
  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) begin
      r_state  <= S_IDLE;
      r_sout   <= 1'b1;
      r_shift  <= '0;
      r_bitidx <= '0;
      r_cnt    <= '0;
      r_div    <= '0;
`ifdef WB_UART_TX_PARITY_EN
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: r_sout <= 1'b1;
        S_START: begin
          r_sout <= 1'b0;
          if (r_cnt == '0) begin
            r_state  <= S_DATA;
            r_cnt    <= r_div;
            r_bitidx <= '0;
          end else r_cnt <= r_cnt - 16'd1;
        end
        S_DATA: begin
          r_sout <= r_shift[0];
          if (r_cnt == '0) begin
            r_cnt    <= r_div;
            r_shift  <= {1'b0, r_shift[7:1]};
            r_bitidx <= r_bitidx + 3'd1;
            if (r_bitidx == 3'd7)
`ifdef WB_UART_TX_PARITY_EN
              r_state <= r_par_en ? S_PARITY : S_STOP;
`else
              r_state <= S_STOP;
`endif
          end else r_cnt <= r_cnt - 16'd1;
        end
`ifdef WB_UART_TX_PARITY_EN
        S_PARITY: begin
          r_sout <= r_par_bit;
          if (r_cnt == '0) begin
            r_state <= S_STOP;
            r_cnt   <= r_div;
          end else r_cnt <= r_cnt - 16'd1;
        end
`endif
        S_STOP: begin
          r_sout <= 1'b1;
          if (r_cnt == '0) r_state <= S_IDLE;
          else             r_cnt   <= r_cnt - 16'd1;
        end
        default: r_state <= S_IDLE;
      endcase
      // Frame start: divider and parity mode are frozen for the whole frame.
      if (w_pop) begin
        r_state <= S_START;
        r_shift <= r_mem[r_rptr];
        r_div   <= r_baud;
        r_cnt   <= r_baud;
`ifdef WB_UART_TX_PARITY_EN
        r_par_en  <= r_ctrl[2];
        r_par_bit <= (^r_mem[r_rptr]) ^ r_ctrl[3];
`endif
      end
    end
  end

endmodule

// File: tb/tb_wb_uart_tx_fifo.sv
// tb_wb_uart_tx_fifo: directed bench for the Wishbone UART transmitter.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_wb_uart_tx_fifo;

  logic        WB_CLK, WB_RST;
  logic [9:0]  WBs_ADR;
  logic        WBs_CYC, WBs_STB, WBs_WE;
  logic [3:0]  WBs_BYTE_STB;
  logic [31:0] WBs_WR_DAT, WBs_RD_DAT;
  logic        WBs_ACK, UART_SOUT_o, UART_Intr_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mark;
  int rise;
  logic [3:0]  ackv;
  logic [31:0] d;
  logic sout_hist [0:4095];
  logic intr_hist [0:4095];
  logic exp_bits [$];

  wb_uart_tx_fifo dut (
    .WB_CLK       (WB_CLK),
    .WB_RST       (WB_RST),
    .WBs_ADR      (WBs_ADR),
    .WBs_CYC      (WBs_CYC),
    .WBs_STB      (WBs_STB),
    .WBs_WE       (WBs_WE),
    .WBs_BYTE_STB (WBs_BYTE_STB),
    .WBs_WR_DAT   (WBs_WR_DAT),
    .WBs_RD_DAT   (WBs_RD_DAT),
    .WBs_ACK      (WBs_ACK),
    .UART_SOUT_o  (UART_SOUT_o),
    .UART_Intr_o  (UART_Intr_o)
  );

  initial begin
    WB_CLK = 1'b0;
    forever #5 WB_CLK = ~WB_CLK;
  end

  // Line history sampled on the falling edge; index k holds the value after the k-th rising edge.
  always @(negedge WB_CLK) begin
    if (cyc < 4096) begin
      sout_hist[cyc] <= UART_SOUT_o;
      intr_hist[cyc] <= UART_Intr_o;
    end
    cyc <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic we, input logic [9:0] adr, input logic [31:0] dat,
                    input logic [3:0] be, output logic [31:0] rd);
    bit got;
    got          = 1'b0;
    WBs_CYC      = 1'b1;
    WBs_STB      = 1'b1;
    WBs_WE       = we;
    WBs_ADR      = adr;
    WBs_WR_DAT   = dat;
    WBs_BYTE_STB = be;
    for (int k = 0; k < 4 && !got; k++) begin
      @(posedge WB_CLK);
      #1;
      if (WBs_ACK) got = 1'b1;
    end
    WBs_CYC = 1'b0;
    WBs_STB = 1'b0;
    WBs_WE  = 1'b0;
    rd      = WBs_RD_DAT;
    if (!got) begin
      checks++;
      errors++;
      $error("FAIL ack_timeout: observed no ACK at adr 0x%03h expected ACK within 4 cycles", adr);
    end
  endtask

  task automatic wr(input logic [9:0] adr, input logic [31:0] dat);
    logic [31:0] tmp;
    wb(1'b1, adr, dat, 4'hF, tmp);
  endtask

  task automatic rd_chk(input string tag, input logic [9:0] adr, input logic [31:0] exp);
    logic [31:0] tmp;
    wb(1'b0, adr, 32'h0, 4'hF, tmp);
    chk(tag, tmp, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge WB_CLK);
    #1;
  endtask

  // Appends the expected line image of one frame (each bit held baud+1 cycles).
  task automatic push_frame(input logic [7:0] b, input int baud, input logic par_en, input logic par_odd);
    logic [10:0] bits;
    int n;
    bits      = '0;
    bits[8:1] = b;
    if (par_en) begin
      bits[9]  = (^b) ^ par_odd;
      bits[10] = 1'b1;
      n        = 11;
    end else begin
      bits[9] = 1'b1;
      n       = 10;
    end
    for (int i = 0; i < n; i++)
      for (int j = 0; j <= baud; j++)
        exp_bits.push_back(bits[i]);
  endtask

  // Compares the recorded line against the expected image; reports mismatching bit count.
  task automatic chk_frame(input string tag, input int start);
    int nbad;
    nbad = 0;
    for (int i = 0; i < exp_bits.size(); i++)
      if (sout_hist[start+i] !== exp_bits[i]) nbad++;
    chk(tag, nbad, 0);
    exp_bits.delete();
  endtask

  initial begin
    WB_RST       = 1'b1;
    WBs_CYC      = 1'b0;
    WBs_STB      = 1'b0;
    WBs_WE       = 1'b0;
    WBs_ADR      = '0;
    WBs_BYTE_STB = '0;
    WBs_WR_DAT   = '0;
    repeat (2) @(posedge WB_CLK);
    #1;
    chk("rst_sout", {31'd0, UART_SOUT_o}, 32'd1);
    chk("rst_ack", {31'd0, WBs_ACK}, 32'd0);
    chk("rst_rd_dat", WBs_RD_DAT, 32'd0);
    chk("rst_intr", {31'd0, UART_Intr_o}, 32'd0);
    WB_RST = 1'b0;
    cycles(1);
    rd_chk("rst_status", 10'h004, 32'h0000_0001);
    rd_chk("rst_baud", 10'h008, 32'd68);

    // Held request: ACK on every other cycle.
    cycles(1);
    WBs_CYC = 1'b1;
    WBs_STB = 1'b1;
    WBs_WE  = 1'b0;
    WBs_ADR = 10'h040;
    for (int i = 0; i < 4; i++) begin
      @(posedge WB_CLK);
      #1;
      ackv[i] = WBs_ACK;
    end
    WBs_CYC = 1'b0;
    WBs_STB = 1'b0;
    chk("held_req_ack", {28'd0, ackv}, 32'h5);

    // BAUD=3, single byte 0xA5.
    wr(10'h008, 32'd3);
    wr(10'h000, 32'hA5);
    mark = cyc;
    cycles(45);
    chk("pre_start_idle", {30'd0, sout_hist[mark], sout_hist[mark+1]}, 32'd3);
    push_frame(8'hA5, 3, 1'b0, 1'b0);
    chk_frame("frame_a5", mark + 2);
    chk("after_frame_idle", {31'd0, sout_hist[mark+42]}, 32'd1);
    rd_chk("status_after_a5", 10'h004, 32'h0000_0001);

    // BAUD=0, three bytes back-to-back with no idle gap.
    wr(10'h008, 32'd0);
    wr(10'h000, 32'h01);
    mark = cyc;
    wr(10'h000, 32'h02);
    wr(10'h000, 32'h03);
    cycles(40);
    push_frame(8'h01, 0, 1'b0, 1'b0);
    push_frame(8'h02, 0, 1'b0, 1'b0);
    push_frame(8'h03, 0, 1'b0, 1'b0);
    chk_frame("b2b_frames", mark + 2);
    rd_chk("status_after_b2b", 10'h004, 32'h0000_0001);

    // BAUD=100: fill FIFO while the first frame is in flight, then overrun.
    wr(10'h008, 32'd100);
    wr(10'h000, 32'h00);
    for (int i = 0; i < 16; i++) wr(10'h000, 32'(i + 1));
    rd_chk("status_full", 10'h004, 32'h0000_1006);
    for (int i = 0; i < 18; i++) wr(10'h000, 32'hEE);
    rd_chk("status_overrun", 10'h004, 32'h0000_100E);
    chk("intr_ovr_masked", {31'd0, UART_Intr_o}, 32'd0);
    wr(10'h00C, 32'h2);
    chk("intr_ovr", {31'd0, UART_Intr_o}, 32'd1);
    wr(10'h004, 32'h8);
    chk("intr_ovr_cleared", {31'd0, UART_Intr_o}, 32'd0);
    rd_chk("status_w1c", 10'h004, 32'h0000_1006);
    wr(10'h000, 32'hEE);
    chk("intr_ovr_again", {31'd0, UART_Intr_o}, 32'd1);
    chk("sout_mid_frame", {31'd0, UART_SOUT_o}, 32'd0);

    // Reset in the middle of a frame.
    WB_RST = 1'b1;
    #1;
    chk("midrst_sout", {31'd0, UART_SOUT_o}, 32'd1);
    chk("midrst_ack", {31'd0, WBs_ACK}, 32'd0);
    chk("midrst_intr", {31'd0, UART_Intr_o}, 32'd0);
    chk("midrst_rd_dat", WBs_RD_DAT, 32'd0);
    @(posedge WB_CLK);
    #1;
    WB_RST = 1'b0;
    rd_chk("midrst_status", 10'h004, 32'h0000_0001);
    rd_chk("midrst_baud", 10'h008, 32'd68);
    rd_chk("midrst_ctrl", 10'h00C, 32'd0);

    // Byte-enable honoured on BAUD: only the low byte changes (68 -> 1).
    wb(1'b1, 10'h008, 32'h0000_FF01, 4'b0001, d);
    rd_chk("baud_byte_en", 10'h008, 32'h0000_0001);

    // Done interrupt: high while idle+empty, low during the frame, back when FSM idles.
    wr(10'h00C, 32'h1);
    chk("intr_done_idle", {31'd0, UART_Intr_o}, 32'd1);
    wr(10'h000, 32'h3C);
    chk("intr_done_busy", {31'd0, UART_Intr_o}, 32'd0);
    mark = cyc;
    cycles(30);
    rise = -1;
    for (int k = 0; k < 29; k++)
      if (rise < 0 && intr_hist[mark+k] === 1'b1) rise = k;
    chk("intr_rise_cycle", rise, 32'd21);
    push_frame(8'h3C, 1, 1'b0, 1'b0);
    chk_frame("frame_3c", mark + 2);
    rd_chk("unmapped_read", 10'h040, 32'hBADF_ABAC);
    rd_chk("txdata_read", 10'h000, 32'h0);
    rd_chk("ctrl_read", 10'h00C, 32'h1);

`ifdef WB_UART_TX_PARITY_EN
    wr(10'h00C, 32'h4);
    wr(10'h000, 32'h07);
    mark = cyc;
    cycles(32);
    push_frame(8'h07, 1, 1'b1, 1'b0);
    chk_frame("parity_even", mark + 2);
    rd_chk("status_after_par", 10'h004, 32'h0000_0001);
    wr(10'h00C, 32'hC);
    wr(10'h000, 32'h07);
    mark = cyc;
    cycles(32);
    push_frame(8'h07, 1, 1'b1, 1'b1);
    chk_frame("parity_odd", mark + 2);
`else
    wr(10'h00C, 32'hF);
    rd_chk("ctrl_no_parity", 10'h00C, 32'h3);
    wr(10'h000, 32'h07);
    mark = cyc;
    cycles(30);
    push_frame(8'h07, 1, 1'b0, 1'b0);
    chk_frame("frame_07_8n1", mark + 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_uart_tx_fifo.md
Name: wb_uart_tx_fifo

Overview:
- Wishbone client UART transmitter. Sits downstream of the AHB-to-FPGA bridge's Wishbone bus and drives the board-level UART serial-out pin.
- Software writes bytes into a transmit FIFO. An 8N1 serializer with a programmable baud divider drains the FIFO.
- Provides status, a sticky overrun flag and a level interrupt for the fabric interrupt input (FB_msg_out).

Parameters:
- ADDRWIDTH, 10, byte-offset width of WBs_ADR seen by this client.
- FIFO_DEPTH_LOG2, 4, log2 of TX FIFO depth (default 16 entries).
- BAUD_DIV_DEFAULT, 16'd68, reset value of BAUD register; bit period = BAUD+1 clocks.
- DEFAULT_READ_VALUE, 32'hBAD_FAB_AC, read data for unmapped offsets.

Ports:
- WB_CLK  input  1  sole clock.
- WB_RST  input  1  asynchronous, active-high reset.
- WBs_ADR  input  ADDRWIDTH  byte address; bits [1:0] ignored.
- WBs_CYC  input  1  cycle/chip select.
- WBs_STB  input  1  strobe.
- WBs_WE  input  1  write enable.
- WBs_BYTE_STB  input  4  byte enables.
- WBs_WR_DAT  input  32  write data.
- WBs_RD_DAT  output  32  read data, registered.
- WBs_ACK  output  1  transfer acknowledge.
- UART_SOUT_o  output  1  serial out, idle high.
- UART_Intr_o  output  1  level interrupt.

Behaviour:
Reset values (WB_RST asserted, asynchronous):
- UART_SOUT_o=1, WBs_ACK=0, WBs_RD_DAT=0, UART_Intr_o=0.
- FIFO empty, count 0; FSM IDLE.
- BAUD=BAUD_DIV_DEFAULT, CTRL=0, OVERRUN=0.
- Reset mid-frame aborts the frame; SOUT returns to 1 immediately.

Bus handshake:
- Request = WBs_CYC & WBs_STB & ~WBs_ACK. WBs_ACK pulses exactly one cycle, in the cycle after the request is seen. A held request yields one ACK per two cycles.
- Write side effects and RD_DAT capture occur on the acknowledging clock edge.

Register map (byte offsets):
- 0x000 TXDATA, W: if BYTE_STB[0], push WR_DAT[7:0]. Reads return 0.
- 0x004 STATUS, R: [FIFO_DEPTH_LOG2+8:8]=count, [3]=OVERRUN, [2]=busy (FSM not IDLE), [1]=full, [0]=empty. Write 1 to bit 3 clears OVERRUN.
- 0x008 BAUD, RW [15:0]; byte enables [1:0] honoured.
- 0x00C CTRL, RW [0]=INT_EN_DONE, [1]=INT_EN_OVR; bits [3:2] per Optional Feature.
- Any other offset: reads return DEFAULT_READ_VALUE; writes are ignored but still acknowledged.

FIFO:
- Depth 2^FIFO_DEPTH_LOG2. Pointers wrap modulo depth; count is FIFO_DEPTH_LOG2+1 bits.
- Push while full (pre-edge full flag): byte dropped, OVERRUN set. This holds even if a pop occurs in the same cycle.
- Push and pop in the same cycle when not full: count unchanged.

Serializer FSM (IDLE, START, DATA, STOP):
- IDLE: if not empty, pop head into shift register, latch BAUD into the bit counter reload, enter START. SOUT goes 0 on the following cycle.
- Each bit lasts BAUD+1 cycles. BAUD=0 gives 1 cycle per bit.
- BAUD changes take effect only at the next frame start.
- START: 1 bit low.
- DATA: 8 bits, LSB first.
- STOP: 1 bit high.
- At the final cycle of STOP: if not empty, pop and go straight to START (no idle gap); else go to IDLE.
- Frame length is 10*(BAUD+1) cycles.

Interrupt (combinational from registers):
- UART_Intr_o = (INT_EN_DONE & empty & IDLE) | (INT_EN_OVR & OVERRUN).

Optional Feature:
Macro WB_UART_TX_PARITY_EN.
- Defined: CTRL[2]=PAR_EN, CTRL[3]=PAR_ODD. With PAR_EN=1, a PARITY state sits between DATA and STOP, transmitting XOR of the 8 data bits, inverted when PAR_ODD=1. Frame becomes 11*(BAUD+1) cycles. PAR_EN/PAR_ODD are latched at frame start.
- Not defined: CTRL[3:2] read 0 and writes are ignored; no PARITY state exists; frames are always 8N1.

Test Plan:
- Reset check: assert WB_RST mid-frame -> SOUT=1, ACK=0, INTR=0, STATUS reads 0x00000001, BAUD reads 68.
- BAUD=3, write TXDATA 0xA5 -> SOUT low starts 2 cycles after ACK. Bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles, 40 cycles total. Then STATUS busy=0, empty=1.
- BAUD=0, write 0x01,0x02,0x03 back-to-back -> 30 contiguous cycles, no idle high between frames, bytes in order.
- BAUD=100, write 17 bytes while the first frame is in flight -> 16 accepted (one popped), final write accepted or OVERRUN per full flag. Write 18 more -> OVERRUN=1. With INT_EN_OVR=1, INTR=1; W1C to STATUS[3] -> INTR=0.
- INT_EN_DONE=1, send one byte -> INTR low during frame, rises in the cycle FSM returns to IDLE. Read offset 0x040 -> 0xBADFABAC.
- With WB_UART_TX_PARITY_EN, PAR_EN=1, PAR_ODD=0, byte 0x07 -> parity bit 1, frame 11*(BAUD+1) cycles. With PAR_ODD=1 -> parity bit 0.
